// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, h/v position counters,
// active-low syncs, visible-window flag and a once-per-frame tick.
module vga_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_DISP_START = 144,
    parameter int H_DISP_END   = 783,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_DISP_START = 35,
    parameter int V_DISP_END   = 514
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_L  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_L  = 10'(V_SYNC);
    localparam logic [9:0] H_DS      = 10'(H_DISP_START);
    localparam logic [9:0] H_DE      = 10'(H_DISP_END);
    localparam logic [9:0] V_DS      = 10'(V_DISP_START);
    localparam logic [9:0] V_DE      = 10'(V_DISP_END);
    localparam logic [9:0] CNT_ONE   = 10'd1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             tick_q, tick_d;
    logic             pix_tick;

    assign pix_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = pix_tick ? '0 : div_q + DIV_ONE;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_ONE;
            end else begin
                h_d = h_q + CNT_ONE;
            end
        end

        // Flags are decoded from the next-state counters so that, once
        // registered, they line up with the counters without a cycle of skew.
        hsync_d  = (h_d >= H_SYNC_L);
        vsync_d  = (v_d >= V_SYNC_L);
        bright_d = (h_d >= H_DS) && (h_d <= H_DE) &&
                   (v_d >= V_DS) && (v_d <= V_DE);

        // The edge that leaves the last visible line enters vertical blanking.
        tick_d   = pix_tick && (h_q == H_LAST) && (v_q == V_DE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
            tick_q   <= tick_d;
        end
    end

    assign pixel_en   = pix_tick;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign bright     = bright_q;
    assign frame_tick = tick_q;

endmodule
